// File: rtl/blc_ref_div_sched.sv
// Round-robin arbiter sharing one bit-serial restoring divider among N_LANE black-level lanes.
// Latency: ack one cycle after capture edge, result 2*DATA_WIDTH edges later (1 edge for cnt==0); no output backpressure, lanes wait on req.
module blc_ref_div_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int N_LANE     = 4,
    localparam int LW        = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_LANE-1:0]              req,
    input  logic [N_LANE*2*DATA_WIDTH-1:0] sum_flat,
    input  logic [N_LANE*CNT_WIDTH-1:0]    cnt_flat,
    output logic [N_LANE-1:0]              ack,
    output logic                           ref_valid,
    output logic [LW-1:0]                  ref_lane,
    output logic [DATA_WIDTH-1:0]          ref_data,
    output logic                           ref_dz,
    output logic                           busy
);

    localparam int SW = 2 * DATA_WIDTH;
    localparam int RW = CNT_WIDTH + 1;
    localparam int IW = $clog2(SW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DZ   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         last_grant_q, last_grant_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [SW-1:0]         quo_q, quo_d;
    logic [CNT_WIDTH-1:0]  div_q, div_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [IW-1:0]         iter_q, iter_d;
    logic [N_LANE-1:0]     ack_q, ack_d;
    logic                  ref_valid_q, ref_valid_d;
    logic [LW-1:0]         ref_lane_q, ref_lane_d;
    logic [DATA_WIDTH-1:0] ref_data_q, ref_data_d;
    logic                  ref_dz_q, ref_dz_d;

    logic [SW-1:0]         lane_sum [N_LANE];
    logic [CNT_WIDTH-1:0]  lane_cnt [N_LANE];

    for (genvar g = 0; g < N_LANE; g++) begin : g_unpack
        assign lane_sum[g] = sum_flat[g*SW +: SW];
        assign lane_cnt[g] = cnt_flat[g*CNT_WIDTH +: CNT_WIDTH];
    end

    // Rotating priority search starting just after the last granted lane.
    logic          gnt_found;
    logic [LW-1:0] gnt_idx;

    always_comb begin
        int            cand;
        logic [LW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= N_LANE; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= N_LANE) begin
                cand = cand - N_LANE;
            end
            cand_idx = LW'(cand);
            if (!gnt_found && req[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [RW-1:0] rem_sh;
    logic [SW-1:0] quo_sh;

    always_comb begin
        rem_sh = {rem_q[CNT_WIDTH-1:0], quo_q[SW-1]};
        quo_sh = {quo_q[SW-2:0], 1'b0};
        if (rem_sh >= {1'b0, div_q}) begin
            rem_sh    = rem_sh - {1'b0, div_q};
            quo_sh[0] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lane_d       = lane_q;
        quo_d        = quo_q;
        div_d        = div_q;
        rem_d        = rem_q;
        iter_d       = iter_q;
        ack_d        = '0;
        ref_valid_d  = 1'b0;
        ref_lane_d   = ref_lane_q;
        ref_data_d   = ref_data_q;
        ref_dz_d     = ref_dz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    last_grant_d   = gnt_idx;
                    lane_d         = gnt_idx;
                    quo_d          = lane_sum[gnt_idx];
                    div_d          = lane_cnt[gnt_idx];
                    rem_d          = '0;
                    iter_d         = '0;
                    ack_d[gnt_idx] = 1'b1;
                    state_d        = (lane_cnt[gnt_idx] == '0) ? ST_DZ : ST_DIV;
                end
            end
            ST_DIV: begin
                rem_d  = rem_sh;
                quo_d  = quo_sh;
                iter_d = iter_q + IW'(1);
                if (iter_q == IW'(SW - 1)) begin
                    iter_d      = '0;
                    ref_valid_d = 1'b1;
                    ref_lane_d  = lane_q;
                    ref_dz_d    = 1'b0;
                    // Quotients that overflow the pixel width clamp to full scale.
                    ref_data_d  = (|quo_sh[SW-1:DATA_WIDTH]) ? '1 : quo_sh[DATA_WIDTH-1:0];
                    state_d     = ST_IDLE;
                end
            end
            ST_DZ: begin
                ref_valid_d = 1'b1;
                ref_lane_d  = lane_q;
                ref_data_d  = '0;
                ref_dz_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= LW'(N_LANE - 1);
            lane_q       <= '0;
            quo_q        <= '0;
            div_q        <= '0;
            rem_q        <= '0;
            iter_q       <= '0;
            ack_q        <= '0;
            ref_valid_q  <= 1'b0;
            ref_lane_q   <= '0;
            ref_data_q   <= '0;
            ref_dz_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lane_q       <= lane_d;
            quo_q        <= quo_d;
            div_q        <= div_d;
            rem_q        <= rem_d;
            iter_q       <= iter_d;
            ack_q        <= ack_d;
            ref_valid_q  <= ref_valid_d;
            ref_lane_q   <= ref_lane_d;
            ref_data_q   <= ref_data_d;
            ref_dz_q     <= ref_dz_d;
        end
    end

    assign ack       = ack_q;
    assign ref_valid = ref_valid_q;
    assign ref_lane  = ref_lane_q;
    assign ref_data  = ref_data_q;
    assign ref_dz    = ref_dz_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
